// File: rtl/algo_ref_pkg.sv
// Shared helpers for the algorithmic-memory reference models: read-during-write
// mode constants, a constant clog2 and the {bank,row} physical-address packer.
package algo_ref_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Caller truncates to BITPADR; a spare-bank report folds into the bank field.
  function automatic logic [31:0] pack_padr(input int bank, input int row, input int bitvrow);
    return 32'((bank << bitvrow) | row);
  endfunction

endpackage

// File: rtl/algo_ref_dly.sv
// Valid+data shift pipeline with async reset. Stage 0 data holds while idle so
// the output keeps its last value between reads.
module algo_ref_dly #(
  parameter int W     = 1,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DELAY-1:0] vld_q;
  logic [W-1:0]     data_q [DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < DELAY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DELAY-1];
  assign data_o = data_q[DELAY-1];

endmodule

// File: rtl/np2_addr.sv
// Splits a flat address into virtual bank (addr % NUMVBNK) and row (addr / NUMVBNK).
module np2_addr #(
  parameter int BITADDR = 4,
  parameter int NUMVBNK = 4,
  parameter int BITVBNK = 2,
  parameter int BITVROW = 2
) (
  input  logic [BITADDR-1:0] addr_i,
  output logic [BITVBNK-1:0] vbadr_o,
  output logic [BITVROW-1:0] vradr_o
);

  assign vbadr_o = BITVBNK'(32'(addr_i) % NUMVBNK);
  assign vradr_o = BITVROW'(32'(addr_i) / NUMVBNK);

endmodule

// File: rtl/algo_nr1w_ref.sv
// Behavioural N-read/1-write virtual-banked memory reference with per-row error
// flags, error injection, read-during-write selection and saturating error counters.
module algo_nr1w_ref
  import algo_ref_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUMADDR   = 16,
  parameter int BITADDR   = 4,
  parameter int NUMVBNK   = 4,
  parameter int BITVBNK   = 2,
  parameter int NUMVROW   = 4,
  parameter int BITVROW   = 2,
  parameter int NUMRDPT   = 2,
  parameter int MEM_DELAY = 2,
  parameter int RDW_MODE  = 0,
  parameter int BITCNT    = 8,
  parameter int BITPADR   = BITVBNK + BITVROW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
  output logic [NUMRDPT-1:0]         read_vld,
  output logic [NUMRDPT*WIDTH-1:0]   dout,
  output logic [NUMRDPT-1:0]         read_serr,
  output logic [NUMRDPT-1:0]         read_derr,
  output logic [NUMRDPT*BITPADR-1:0] read_padr,
  input  logic                       write,
  input  logic [BITADDR-1:0]         wr_adr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       inj_vld,
  input  logic [BITVBNK:0]           inj_bank,
  input  logic [BITVROW-1:0]         inj_row,
  output logic [BITCNT-1:0]          serr_cnt,
  output logic [BITCNT-1:0]          derr_cnt
);

  localparam int BITFC  = clog2(NUMVBNK + 2);
  localparam int BITSUM = clog2(NUMRDPT + 1);
  localparam int PW     = WIDTH + BITPADR + 2;
  localparam logic [BITCNT-1:0] CNT_MAX = '1;
  localparam logic [BITVBNK:0]  SPARE   = (BITVBNK+1)'(NUMVBNK);

  logic [WIDTH-1:0]                  mem_q [NUMADDR];
  logic [NUMVBNK:0][NUMVROW-1:0]     err_q, err_d;
  logic [BITVBNK-1:0]                wr_bank_s;
  logic [BITVROW-1:0]                wr_row_s;
  logic [NUMRDPT-1:0]                sinc_v_s, dinc_v_s;
  logic [BITSUM-1:0]                 sinc_s, dinc_s;
  logic [BITCNT-1:0]                 serr_cnt_q, serr_cnt_d, derr_cnt_q, derr_cnt_d;

  function automatic logic [BITCNT-1:0] sat_add(input logic [BITCNT-1:0] c,
                                                input logic [BITSUM-1:0] inc);
    logic [BITCNT+BITSUM-1:0] s;
    s = {{BITSUM{1'b0}}, c} + {{BITCNT{1'b0}}, inc};
    return (s > {{BITSUM{1'b0}}, CNT_MAX}) ? CNT_MAX : s[BITCNT-1:0];
  endfunction

  np2_addr #(.BITADDR(BITADDR), .NUMVBNK(NUMVBNK), .BITVBNK(BITVBNK), .BITVROW(BITVROW))
    u_wr_split (.addr_i(wr_adr), .vbadr_o(wr_bank_s), .vradr_o(wr_row_s));

  // Array contents survive reset; only the flags and pipelines are cleared.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[wr_adr] <= din;
    end
  end

  // Write clears the data bank and spare flags of its row; injection applied last so it wins.
  always_comb begin
    err_d = err_q;
    if (write) begin
      err_d[{1'b0, wr_bank_s}][wr_row_s] = 1'b0;
      err_d[SPARE][wr_row_s]             = 1'b0;
    end
    if (inj_vld && (inj_bank <= SPARE)) begin
      err_d[inj_bank][inj_row] = 1'b1;
    end
  end

  always_comb begin
    sinc_s = '0;
    dinc_s = '0;
    for (int p = 0; p < NUMRDPT; p++) begin
      sinc_s = sinc_s + BITSUM'(sinc_v_s[p]);
      dinc_s = dinc_s + BITSUM'(dinc_v_s[p]);
    end
    serr_cnt_d = sat_add(serr_cnt_q, sinc_s);
    derr_cnt_d = sat_add(derr_cnt_q, dinc_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= '0;
      serr_cnt_q <= '0;
      derr_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      serr_cnt_q <= serr_cnt_d;
      derr_cnt_q <= derr_cnt_d;
    end
  end

  assign serr_cnt = serr_cnt_q;
  assign derr_cnt = derr_cnt_q;

  for (genvar p = 0; p < NUMRDPT; p++) begin : g_rd
    logic [BITADDR-1:0] adr_s;
    logic [BITVBNK-1:0] bank_s, low_s;
    logic [BITVROW-1:0] row_s;
    logic [BITFC-1:0]   fcnt_s;
    logic               found_s, serr_s, derr_s, vout_s;
    logic [BITPADR-1:0] padr_s;
    logic [WIDTH-1:0]   data_s;
    logic [PW-1:0]      pin_s, pout_s;

    assign adr_s = rd_adr[p*BITADDR +: BITADDR];

    np2_addr #(.BITADDR(BITADDR), .NUMVBNK(NUMVBNK), .BITVBNK(BITVBNK), .BITVROW(BITVROW))
      u_rd_split (.addr_i(adr_s), .vbadr_o(bank_s), .vradr_o(row_s));

    // Count flagged banks on the row (spare included) and find the lowest one.
    always_comb begin
      fcnt_s  = '0;
      low_s   = '0;
      found_s = 1'b0;
      for (int b = 0; b <= NUMVBNK; b++) begin
        if (err_q[b][row_s]) begin
          fcnt_s = fcnt_s + BITFC'(1);
          if (!found_s) begin
            low_s   = BITVBNK'(b);
            found_s = 1'b1;
          end
        end
      end
    end

    always_comb begin
      if ((RDW_MODE == RDW_NEW) && write && (wr_adr == adr_s)) begin
        data_s = din;
      end else begin
        data_s = mem_q[adr_s];
      end
    end

    assign serr_s = (fcnt_s != '0);
    assign derr_s = (fcnt_s > BITFC'(1));
    assign padr_s = BITPADR'(pack_padr(found_s ? int'(low_s) : int'(bank_s), int'(row_s), BITVROW));
    assign pin_s  = {serr_s, derr_s, padr_s, data_s};

    algo_ref_dly #(.W(PW), .DELAY(MEM_DELAY)) u_dly (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (read[p]),
      .data_i (pin_s),
      .vld_o  (vout_s),
      .data_o (pout_s)
    );

    // Held stage data carries stale flags, so they are qualified by valid.
    assign read_vld[p]                      = vout_s;
    assign read_serr[p]                     = vout_s & pout_s[PW-1];
    assign read_derr[p]                     = vout_s & pout_s[PW-2];
    assign read_padr[p*BITPADR +: BITPADR]  = pout_s[WIDTH +: BITPADR];
    assign dout[p*WIDTH +: WIDTH]           = pout_s[WIDTH-1:0];

    assign sinc_v_s[p] = read[p] & serr_s & ~derr_s;
    assign dinc_v_s[p] = read[p] & derr_s;
  end

endmodule

// File: tb/tb_algo_nr1w_ref.sv
// Directed bench for algo_nr1w_ref: two instances (old-data and new-data RDW) share
// stimulus; a behavioural model queues expected read results for comparison.
module tb_algo_nr1w_ref;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] read = '0;
  logic [7:0] rd_adr = '0;
  logic       write = 1'b0;
  logic [3:0] wr_adr = '0;
  logic [3:0] din = '0;
  logic       inj_vld = 1'b0;
  logic [2:0] inj_bank = '0;
  logic [1:0] inj_row = '0;

  logic [1:0] vld0, serr0, derr0, vld1, serr1, derr1;
  logic [7:0] dout0, padr0, dout1, padr1;
  logic [7:0] scnt0, dcnt0, scnt1, dcnt1;

  typedef struct {
    int         port;
    int         due;
    logic [3:0] d_old;
    logic [3:0] d_new;
    logic       serr;
    logic       derr;
    logic [3:0] padr;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] m_mem [16];
  logic [3:0] m_err [5];
  int         m_scnt, m_dcnt, cyc, n_vec, n_fail;

  algo_nr1w_ref #(.RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .read(read), .rd_adr(rd_adr),
    .read_vld(vld0), .dout(dout0), .read_serr(serr0), .read_derr(derr0), .read_padr(padr0),
    .write(write), .wr_adr(wr_adr), .din(din),
    .inj_vld(inj_vld), .inj_bank(inj_bank), .inj_row(inj_row),
    .serr_cnt(scnt0), .derr_cnt(dcnt0)
  );

  algo_nr1w_ref #(.RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .read(read), .rd_adr(rd_adr),
    .read_vld(vld1), .dout(dout1), .read_serr(serr1), .read_derr(derr1), .read_padr(padr1),
    .write(write), .wr_adr(wr_adr), .din(din),
    .inj_vld(inj_vld), .inj_bank(inj_bank), .inj_row(inj_row),
    .serr_cnt(scnt1), .derr_cnt(dcnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int p, input int a);
    logic [3:0] a4;
    a4 = a[3:0];
    read[p] = 1'b1;
    rd_adr[p*4 +: 4] = a4;
  endtask

  task automatic check();
    exp_t e;
    bit   hit;
    for (int p = 0; p < 2; p++) begin
      hit = 1'b0;
      if (sbq.size() > 0 && sbq[0].due == cyc && sbq[0].port == p) begin
        e = sbq.pop_front();
        hit = 1'b1;
      end
      chk($sformatf("vld0_p%0d_c%0d", p, cyc), vld0[p], hit);
      chk($sformatf("vld1_p%0d_c%0d", p, cyc), vld1[p], hit);
      if (hit) begin
        chk($sformatf("dout_old_p%0d_c%0d", p, cyc), dout0[p*4 +: 4], e.d_old);
        chk($sformatf("dout_new_p%0d_c%0d", p, cyc), dout1[p*4 +: 4], e.d_new);
        chk($sformatf("serr_p%0d_c%0d", p, cyc), {serr0[p], serr1[p]}, {e.serr, e.serr});
        chk($sformatf("derr_p%0d_c%0d", p, cyc), {derr0[p], derr1[p]}, {e.derr, e.derr});
        chk($sformatf("padr_p%0d_c%0d", p, cyc), {padr0[p*4 +: 4], padr1[p*4 +: 4]}, {e.padr, e.padr});
      end else begin
        chk($sformatf("idle_err_p%0d_c%0d", p, cyc), {serr0[p], derr0[p]}, 2'b00);
      end
    end
    chk($sformatf("serr_cnt_c%0d", cyc), {scnt0, scnt1}, {8'(m_scnt), 8'(m_scnt)});
    chk($sformatf("derr_cnt_c%0d", cyc), {dcnt0, dcnt1}, {8'(m_dcnt), 8'(m_dcnt)});
  endtask

  // One clock: predict reads from pre-edge model state, advance model, compare.
  task automatic tick();
    exp_t       e;
    logic [3:0] ra;
    int         a, bank, row, c, low, pb, sinc, dinc;
    logic [1:0] pb2, row2;
    sinc = 0;
    dinc = 0;
    for (int p = 0; p < 2; p++) begin
      if (read[p]) begin
        ra = rd_adr[p*4 +: 4];
        a = int'(ra);
        bank = a % 4;
        row = a / 4;
        c = 0;
        low = -1;
        for (int b = 0; b < 5; b++) begin
          if (m_err[b][row]) begin
            c++;
            if (low < 0) low = b;
          end
        end
        pb = (c >= 1) ? low : bank;
        pb2 = pb[1:0];
        row2 = row[1:0];
        e.port = p;
        e.due = cyc + 2;
        e.d_old = m_mem[a];
        e.d_new = (write && int'(wr_adr) == a) ? din : m_mem[a];
        e.serr = (c >= 1);
        e.derr = (c >= 2);
        e.padr = {pb2, row2};
        if (c == 1) sinc++;
        if (c >= 2) dinc++;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    if (write) begin
      m_mem[wr_adr] = din;
      m_err[int'(wr_adr) % 4][int'(wr_adr) / 4] = 1'b0;
      m_err[4][int'(wr_adr) / 4] = 1'b0;
    end
    if (inj_vld && inj_bank <= 3'd4) m_err[inj_bank][inj_row] = 1'b1;
    m_scnt = (m_scnt + sinc > 255) ? 255 : m_scnt + sinc;
    m_dcnt = (m_dcnt + dinc > 255) ? 255 : m_dcnt + dinc;
    @(negedge clk);
    check();
    read = '0;
    write = 1'b0;
    inj_vld = 1'b0;
  endtask

  task automatic do_write(input int a, input int d);
    logic [3:0] a4, d4;
    a4 = a[3:0];
    d4 = d[3:0];
    write = 1'b1;
    wr_adr = a4;
    din = d4;
  endtask

  task automatic do_inj(input int b, input int r);
    logic [2:0] b3;
    logic [1:0] r2;
    b3 = b[2:0];
    r2 = r[1:0];
    inj_vld = 1'b1;
    inj_bank = b3;
    inj_row = r2;
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    cyc = 0;
    m_scnt = 0;
    m_dcnt = 0;
    for (int b = 0; b < 5; b++) m_err[b] = '0;

    repeat (2) @(negedge clk);
    chk("rst_vld", {vld0, vld1}, 4'b0000);
    chk("rst_dout", {dout0, dout1}, 16'h0000);
    chk("rst_padr", {padr0, padr1}, 16'h0000);
    chk("rst_cnt", {scnt0, dcnt0, scnt1, dcnt1}, 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      do_write(a, (a * 7 + 3) % 16);
      tick();
    end

    // Plain write then read: padr {1,1}
    do_write(5, 10); tick();
    set_rd(0, 5); tick(); tick(); tick();

    // Single then double flagged row
    do_inj(1, 1); tick();
    set_rd(0, 5); tick(); tick(); tick();
    chk("serr_cnt_after_single", scnt0, 8'd1);
    do_inj(4, 1); tick();
    set_rd(0, 5); set_rd(1, 1); tick(); tick(); tick();
    chk("derr_cnt_after_double", dcnt0, 8'd1);

    // Injection beats a same-cycle write clear on bank1; spare still clears
    do_write(5, 12); do_inj(1, 1); tick();
    set_rd(0, 5); tick(); tick(); tick();
    do_write(5, 6); tick();
    set_rd(0, 5); set_rd(1, 5); tick(); tick(); tick();

    // Read-during-write, both ports on the same address
    do_write(2, 7); tick();
    do_write(2, 3); set_rd(0, 2); set_rd(1, 2); tick(); tick(); tick();

    // Counter saturation on a single-flag row
    do_inj(0, 3); tick();
    for (int i = 0; i < 200; i++) begin
      set_rd(0, 12); set_rd(1, 12); tick();
    end
    tick(); tick();
    chk("serr_cnt_saturated", {scnt0, scnt1}, 16'hFFFF);

    // Async reset one cycle before the read would return
    set_rd(0, 12); tick();
    #2 rst = 1'b1;
    #1;
    sbq.delete();
    m_scnt = 0;
    m_dcnt = 0;
    for (int b = 0; b < 5; b++) m_err[b] = '0;
    chk("rst_mid_cnt", {scnt0, dcnt0}, 16'h0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rst_mid_vld", {vld0, vld1}, 4'b0000);
    rst = 1'b0;
    tick(); tick();
    set_rd(0, 12); set_rd(1, 5); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
